// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, constants and the byte-lane merge helper for the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int MEM_DW = 16;

  localparam logic [MEM_DW-1:0] LANE_LO = 16'h00FF;
  localparam logic [MEM_DW-1:0] LANE_HI = 16'hFF00;

  // Arbiter FSM state encoding
  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t MERGE = 1'b1;

  // Which requester owns a grant or an outstanding read
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DS = 1'b1
  } port_t;

  // Replace the enabled byte lanes of old_word with those of new_word
  function automatic logic [MEM_DW-1:0] merge_bytes(
    input logic [MEM_DW-1:0] old_word,
    input logic [MEM_DW-1:0] new_word,
    input logic [1:0]        be
  );
    logic [MEM_DW-1:0] mask;
    mask = (be[1] ? LANE_HI : '0) | (be[0] ? LANE_LO : '0);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Winner selection: DS has fixed priority, but after MAX_STREAK consecutive DS wins
// while IF is waiting, IF is forced through once.
module mem_port_arbiter_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  if_req,
  input  logic  ds_req,
  input  logic  advance,
  output port_t winner,
  output logic  valid
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak_reg;
  logic          ds_wins;

  // Pick the winner from the current requests and the DS streak
  always_comb begin
    ds_wins = ds_req && !(if_req && (streak_reg == STREAK_MAX));
    valid   = advance && (ds_req || if_req);
    winner  = ds_wins ? PORT_DS : PORT_IF;
  end

  // Count DS wins while IF waits; an IF win or an idle IF clears it, a stall holds it
  always_ff @(posedge clock) begin
    if (reset) begin
      streak_reg <= '0;
    end else if (advance) begin
      if (!if_req || !ds_wins) begin
        streak_reg <= '0;
      end else if (streak_reg != STREAK_MAX) begin
        streak_reg <= streak_reg + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (IF) and
// data load/store (DS). Byte writes become a read followed by a merged write.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ds_req,
  input  logic                  ds_we,
  input  logic [1:0]            ds_be,
  input  logic [ADDR_WIDTH-1:0] ds_addr,
  input  logic [DATA_WIDTH-1:0] ds_wdata,
  output logic                  ds_gnt,
  output logic                  ds_rvalid,
  output logic [DATA_WIDTH-1:0] ds_rdata,
  output logic                  to_mem_mem_enable,
  output logic                  to_mem_read_enable,
  output logic                  to_mem_write_enable,
  output logic [ADDR_WIDTH-1:0] to_mem_address,
  output logic [DATA_WIDTH-1:0] to_mem_data,
  input  logic [DATA_WIDTH-1:0] from_mem_data
);

  state_t                state_reg;
  logic                  pending_reg;
  port_t                 tag_reg;
  logic [ADDR_WIDTH-1:0] lat_addr_reg;
  logic [DATA_WIDTH-1:0] lat_wdata_reg;
  logic [1:0]            lat_be_reg;

  logic  advance;
  logic  win_valid;
  port_t winner;
  logic  grant_if;
  logic  grant_ds;
  logic  ds_full;
  logic  ds_partial;
  logic  read_issue;

  // Arbitration only happens in IDLE and outside reset
  assign advance = (state_reg == IDLE) && !reset;

  mem_port_arbiter_prio #(
    .MAX_STREAK(MAX_STREAK)
  ) u_prio (
    .clock  (clock),
    .reset  (reset),
    .if_req (if_req),
    .ds_req (ds_req),
    .advance(advance),
    .winner (winner),
    .valid  (win_valid)
  );

  // Decode the grant into the kind of memory operation it needs
  always_comb begin
    grant_if   = win_valid && (winner == PORT_IF);
    grant_ds   = win_valid && (winner == PORT_DS);
    ds_full    = grant_ds && ds_we && (ds_be == 2'b11);
    ds_partial = grant_ds && ds_we && ((ds_be == 2'b01) || (ds_be == 2'b10));
    read_issue = grant_if || (grant_ds && !ds_we);
  end

  assign if_gnt    = grant_if;
  assign ds_gnt    = grant_ds;
  assign if_rvalid = !reset && pending_reg && (tag_reg == PORT_IF);
  assign ds_rvalid = !reset && pending_reg && (tag_reg == PORT_DS);
  assign if_rdata  = from_mem_data;
  assign ds_rdata  = from_mem_data;

  // Drive the memory: merge write in MERGE, otherwise the winner's access, else all zero
  always_comb begin
    to_mem_mem_enable   = 1'b0;
    to_mem_read_enable  = 1'b0;
    to_mem_write_enable = 1'b0;
    to_mem_address      = '0;
    to_mem_data         = '0;
    if ((state_reg == MERGE) && !reset) begin
      to_mem_mem_enable   = 1'b1;
      to_mem_write_enable = 1'b1;
      to_mem_address      = lat_addr_reg;
      to_mem_data         = merge_bytes(from_mem_data, lat_wdata_reg, lat_be_reg);
    end else if (read_issue || ds_partial) begin
      to_mem_mem_enable  = 1'b1;
      to_mem_read_enable = 1'b1;
      to_mem_address     = grant_if ? if_addr : ds_addr;
    end else if (ds_full) begin
      to_mem_mem_enable   = 1'b1;
      to_mem_write_enable = 1'b1;
      to_mem_address      = ds_addr;
      to_mem_data         = ds_wdata;
    end
  end

  // FSM: a partial write spends exactly one cycle in MERGE
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else if (state_reg == MERGE) begin
      state_reg <= IDLE;
    end else if (ds_partial) begin
      state_reg <= MERGE;
    end
  end

  // Track the single outstanding read and which port it belongs to
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg <= 1'b0;
      tag_reg     <= PORT_IF;
    end else begin
      pending_reg <= read_issue;
      tag_reg     <= grant_if ? PORT_IF : PORT_DS;
    end
  end

  // Capture the partial write so the merge cycle does not depend on the requester
  always_ff @(posedge clock) begin
    if (ds_partial) begin
      lat_addr_reg  <= ds_addr;
      lat_wdata_reg <= ds_wdata;
      lat_be_reg    <= ds_be;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration and memory contents.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        ds_req;
  logic        ds_we;
  logic [1:0]  ds_be;
  logic [11:0] ds_addr;
  logic [15:0] ds_wdata;
  logic        ds_gnt;
  logic        ds_rvalid;
  logic [15:0] ds_rdata;
  logic        to_mem_mem_enable;
  logic        to_mem_read_enable;
  logic        to_mem_write_enable;
  logic [11:0] to_mem_address;
  logic [15:0] to_mem_data;
  logic [15:0] from_mem_data;

  int total = 0;
  int bad   = 0;

  // Memory model and a backdoor preload path
  logic [15:0] mem [0:4095];
  logic [15:0] mem_q;
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [15:0] poke_data = '0;

  logic [34:0] all_outs;
  assign all_outs = {if_gnt, ds_gnt, if_rvalid, ds_rvalid, to_mem_mem_enable,
                     to_mem_read_enable, to_mem_write_enable, to_mem_address, to_mem_data};

  always #5 clock = ~clock;

  // Synchronous single-port memory: write and read sampled at the rising edge
  always @(posedge clock) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (to_mem_mem_enable && to_mem_write_enable) mem[to_mem_address] <= to_mem_data;
    if (to_mem_mem_enable && to_mem_read_enable) mem_q <= mem[to_mem_address];
  end
  assign from_mem_data = mem_q;

  mem_port_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .if_req             (if_req),
    .if_addr            (if_addr),
    .if_gnt             (if_gnt),
    .if_rvalid          (if_rvalid),
    .if_rdata           (if_rdata),
    .ds_req             (ds_req),
    .ds_we              (ds_we),
    .ds_be              (ds_be),
    .ds_addr            (ds_addr),
    .ds_wdata           (ds_wdata),
    .ds_gnt             (ds_gnt),
    .ds_rvalid          (ds_rvalid),
    .ds_rdata           (ds_rdata),
    .to_mem_mem_enable  (to_mem_mem_enable),
    .to_mem_read_enable (to_mem_read_enable),
    .to_mem_write_enable(to_mem_write_enable),
    .to_mem_address     (to_mem_address),
    .to_mem_data        (to_mem_data),
    .from_mem_data      (from_mem_data)
  );

  // One line per accepted transaction
  always @(negedge clock) begin
    if (if_gnt) $display("txn t=%0t IF read addr=%h", $time, if_addr);
    if (ds_gnt) $display("txn t=%0t DS %s addr=%h be=%b wdata=%h", $time,
                         ds_we ? "write" : "read", ds_addr, ds_be, ds_wdata);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    ds_req = 1'b0; ds_we = 1'b0; ds_be = 2'b00; ds_addr = '0; ds_wdata = '0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 12'h123;
    ds_req = 1'b1; ds_we = 1'b1; ds_be = 2'b01; ds_addr = 12'h321;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      total++;
      if (all_outs !== '0) begin
        bad++; $display("FAIL reset_outputs: got %h want 0", all_outs);
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL idle_outputs: got %h want 0", all_outs);
    end
    tick();
  endtask

  task automatic test_if_read();
    poke(12'h010, 16'hBEEF);
    if_req = 1'b1; if_addr = 12'h010;
    @(negedge clock);
    total++;
    if (if_gnt !== 1'b1 || ds_gnt !== 1'b0) begin
      bad++; $display("FAIL if_read_gnt: got if=%b ds=%b want 1 0", if_gnt, ds_gnt);
    end
    total++;
    if ({to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable} !== 3'b110 ||
        to_mem_address !== 12'h010) begin
      bad++; $display("FAIL if_read_mem: got en/rd/wr=%b%b%b addr=%h want 110 010",
                      to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable, to_mem_address);
    end
    tick();
    if_req = 1'b0;
    @(negedge clock);
    total++;
    if (if_rvalid !== 1'b1 || ds_rvalid !== 1'b0 || if_rdata !== 16'hBEEF) begin
      bad++; $display("FAIL if_read_data: got rv=%b/%b data=%h want 1/0 beef",
                      if_rvalid, ds_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_byte_rmw();
    poke(12'h020, 16'h1234);
    ds_req = 1'b1; ds_we = 1'b1; ds_be = 2'b10; ds_addr = 12'h020; ds_wdata = 16'hAB00;
    if_req = 1'b1; if_addr = 12'h011;
    @(negedge clock);
    total++;
    if (ds_gnt !== 1'b1 || if_gnt !== 1'b0 || to_mem_read_enable !== 1'b1 ||
        to_mem_write_enable !== 1'b0 || to_mem_address !== 12'h020) begin
      bad++; $display("FAIL rmw_read: got ds=%b if=%b rd=%b wr=%b addr=%h want 1 0 1 0 020",
                      ds_gnt, if_gnt, to_mem_read_enable, to_mem_write_enable, to_mem_address);
    end
    tick();
    ds_req = 1'b0;
    @(negedge clock);
    total++;
    if ({if_gnt, ds_gnt, if_rvalid, ds_rvalid} !== 4'b0000) begin
      bad++; $display("FAIL rmw_merge_quiet: got gnt/rv=%b%b%b%b want 0000",
                      if_gnt, ds_gnt, if_rvalid, ds_rvalid);
    end
    total++;
    if ({to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable} !== 3'b101 ||
        to_mem_address !== 12'h020 || to_mem_data !== 16'hAB34) begin
      bad++; $display("FAIL rmw_merge_write: got en/rd/wr=%b%b%b addr=%h data=%h want 101 020 ab34",
                      to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable,
                      to_mem_address, to_mem_data);
    end
    tick();
    @(negedge clock);
    total++;
    if (if_gnt !== 1'b1) begin
      bad++; $display("FAIL rmw_if_after: got if_gnt=%b want 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    @(negedge clock);
    total++;
    if (mem[12'h020] !== 16'hAB34) begin
      bad++; $display("FAIL rmw_mem: got %h want ab34", mem[12'h020]);
    end
    tick();
  endtask

  task automatic test_starvation();
    bit exp_ds [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    ds_req = 1'b1; ds_we = 1'b0; ds_addr = 12'h001;
    if_req = 1'b1; if_addr = 12'h002;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if ({ds_gnt, if_gnt} !== (exp_ds[i] ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL starve_seq[%0d]: got ds=%b if=%b want ds=%b if=%b",
                        i, ds_gnt, if_gnt, exp_ds[i], !exp_ds[i]);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    poke(12'h001, 16'h1111);
    poke(12'h002, 16'h2222);
    ds_req = 1'b1; ds_we = 1'b0; ds_addr = 12'h001;
    if_req = 1'b1; if_addr = 12'h002;
    @(negedge clock);
    total++;
    if (ds_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL simul_first: got ds=%b if=%b want 1 0", ds_gnt, if_gnt);
    end
    tick();
    ds_req = 1'b0;
    @(negedge clock);
    total++;
    if (ds_rvalid !== 1'b1 || if_rvalid !== 1'b0 || ds_rdata !== 16'h1111 || if_gnt !== 1'b1) begin
      bad++; $display("FAIL simul_second: got dsrv=%b ifrv=%b data=%h if_gnt=%b want 1 0 1111 1",
                      ds_rvalid, if_rvalid, ds_rdata, if_gnt);
    end
    tick();
    if_req = 1'b0;
    @(negedge clock);
    total++;
    if (if_rvalid !== 1'b1 || ds_rvalid !== 1'b0 || if_rdata !== 16'h2222) begin
      bad++; $display("FAIL simul_third: got ifrv=%b dsrv=%b data=%h want 1 0 2222",
                      if_rvalid, ds_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_reset_in_merge();
    poke(12'h030, 16'h5555);
    ds_req = 1'b1; ds_we = 1'b1; ds_be = 2'b01; ds_addr = 12'h030; ds_wdata = 16'h00AA;
    @(negedge clock);
    total++;
    if (ds_gnt !== 1'b1) begin
      bad++; $display("FAIL rstmerge_gnt: got %b want 1", ds_gnt);
    end
    tick();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL rstmerge_outs: got %h want 0", all_outs);
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (all_outs !== '0 || mem[12'h030] !== 16'h5555) begin
      bad++; $display("FAIL rstmerge_after: got outs=%h mem=%h want 0 5555", all_outs, mem[12'h030]);
    end
    tick();
    if_req = 1'b1; if_addr = 12'h030;
    @(negedge clock);
    total++;
    if (if_gnt !== 1'b1) begin
      bad++; $display("FAIL rstmerge_idle: got if_gnt=%b want 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    @(negedge clock);
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 16'h5555) begin
      bad++; $display("FAIL rstmerge_readback: got rv=%b data=%h want 1 5555", if_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_full_write();
    ds_req = 1'b1; ds_we = 1'b1; ds_be = 2'b11; ds_addr = 12'h040; ds_wdata = 16'hCAFE;
    @(negedge clock);
    total++;
    if (ds_gnt !== 1'b1 || {to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable} !== 3'b101 ||
        to_mem_address !== 12'h040 || to_mem_data !== 16'hCAFE) begin
      bad++; $display("FAIL full_write: got gnt=%b en/rd/wr=%b%b%b addr=%h data=%h want 1 101 040 cafe",
                      ds_gnt, to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable,
                      to_mem_address, to_mem_data);
    end
    tick();
    ds_we = 1'b0;
    @(negedge clock);
    total++;
    if (ds_gnt !== 1'b1 || to_mem_write_enable !== 1'b0 || ds_rvalid !== 1'b0) begin
      bad++; $display("FAIL full_readreq: got gnt=%b wr=%b rv=%b want 1 0 0",
                      ds_gnt, to_mem_write_enable, ds_rvalid);
    end
    tick();
    ds_req = 1'b0;
    @(negedge clock);
    total++;
    if (ds_rvalid !== 1'b1 || ds_rdata !== 16'hCAFE) begin
      bad++; $display("FAIL full_readback: got rv=%b data=%h want 1 cafe", ds_rvalid, ds_rdata);
    end
    tick();
    ds_req = 1'b1; ds_we = 1'b1; ds_be = 2'b00; ds_wdata = 16'h0BAD;
    @(negedge clock);
    total++;
    if (ds_gnt !== 1'b1 || to_mem_mem_enable !== 1'b0) begin
      bad++; $display("FAIL be00: got gnt=%b en=%b want 1 0", ds_gnt, to_mem_mem_enable);
    end
    tick();
    ds_req = 1'b0;
    @(negedge clock);
    total++;
    if (ds_rvalid !== 1'b0 || mem[12'h040] !== 16'hCAFE) begin
      bad++; $display("FAIL be00_after: got rv=%b mem=%h want 0 cafe", ds_rvalid, mem[12'h040]);
    end
    tick();
  endtask

  // Random traffic on 16 addresses against a model of the arbitration rules
  task automatic test_random();
    logic [15:0] sh [16];
    int   m_streak = 0;
    bit   m_merge  = 0;
    bit   m_rv_if  = 0;
    bit   m_rv_ds  = 0;
    logic [15:0] m_rv_data = '0;
    bit   e_ds, e_if;
    logic [15:0] old_w;
    for (int i = 0; i < 16; i++) begin
      sh[i] = 16'($urandom);
      poke(12'(i), sh[i]);
    end
    idle_inputs();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!if_req && $urandom_range(0, 99) < 60) begin
        if_req = 1'b1; if_addr = 12'($urandom_range(0, 15));
      end
      if (!ds_req && $urandom_range(0, 99) < 60) begin
        ds_req = 1'b1; ds_we = 1'($urandom_range(0, 1)); ds_be = 2'($urandom_range(0, 3));
        ds_addr = 12'($urandom_range(0, 15)); ds_wdata = 16'($urandom);
      end
      @(negedge clock);
      if (m_merge) begin
        e_ds = 0; e_if = 0;
      end else begin
        e_ds = ds_req && !(if_req && m_streak == 4);
        e_if = if_req && !e_ds;
      end
      total++;
      if (ds_gnt !== e_ds || if_gnt !== e_if) begin
        bad++; $display("FAIL rand_gnt[%0d]: got ds=%b if=%b want ds=%b if=%b",
                        cyc, ds_gnt, if_gnt, e_ds, e_if);
      end
      total++;
      if (if_rvalid !== m_rv_if || ds_rvalid !== m_rv_ds) begin
        bad++; $display("FAIL rand_rvalid[%0d]: got if=%b ds=%b want if=%b ds=%b",
                        cyc, if_rvalid, ds_rvalid, m_rv_if, m_rv_ds);
      end
      if (m_rv_if || m_rv_ds) begin
        total++;
        if ((m_rv_if ? if_rdata : ds_rdata) !== m_rv_data) begin
          bad++; $display("FAIL rand_rdata[%0d]: got %h want %h",
                          cyc, m_rv_if ? if_rdata : ds_rdata, m_rv_data);
        end
      end
      // Advance the model by one cycle
      m_rv_if   = e_if;
      m_rv_ds   = e_ds && !ds_we;
      m_rv_data = e_if ? sh[if_addr[3:0]] : sh[ds_addr[3:0]];
      if (!m_merge) begin
        if (!if_req || e_if) m_streak = 0;
        else if (e_ds && m_streak < 4) m_streak++;
      end
      m_merge = 0;
      if (e_ds && ds_we && ds_be != 2'b00) begin
        old_w = sh[ds_addr[3:0]];
        sh[ds_addr[3:0]] = {ds_be[1] ? ds_wdata[15:8] : old_w[15:8],
                            ds_be[0] ? ds_wdata[7:0]  : old_w[7:0]};
        m_merge = (ds_be != 2'b11);
      end
      tick();
      if (e_if) if_req = 1'b0;
      if (e_ds) ds_req = 1'b0;
    end
    idle_inputs();
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (mem[i] !== sh[i]) begin
        bad++; $display("FAIL rand_mem[%0d]: got %h want %h", i, mem[i], sh[i]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_if_read();
    test_byte_rmw();
    test_starvation();
    test_simultaneous();
    test_reset_in_merge();
    test_full_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit, 4096-word synchronous memory between two requesters inside the cpu: instruction fetch (IF) and data load/store (DS).
- Owns the memory control signals (enable, read enable, write enable, address, write data).
- Uses fixed DS priority with an anti-starvation streak limit for IF.
- Implements byte writes as a 2-cycle read-modify-write (RMW), because the memory has no byte enables.

Parameters:
- ADDR_WIDTH, 12, word address width.
- DATA_WIDTH, 16, memory word width; two byte lanes.
- MAX_STREAK, 4, number of consecutive DS grants allowed while IF waits before IF is forced through.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request.
- if_addr  in  ADDR_WIDTH  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DATA_WIDTH  IF read data.
- ds_req  in  1  DS request.
- ds_we  in  1  1 = write, 0 = read.
- ds_be  in  2  byte enables; [1] = bits 15:8, [0] = bits 7:0; ignored on reads.
- ds_addr  in  ADDR_WIDTH  DS word address.
- ds_wdata  in  DATA_WIDTH  DS write data.
- ds_gnt  out  1  DS request accepted this cycle.
- ds_rvalid  out  1  DS read data valid.
- ds_rdata  out  DATA_WIDTH  DS read data.
- to_mem_mem_enable  out  1  memory enable.
- to_mem_read_enable  out  1  memory read strobe.
- to_mem_write_enable  out  1  memory write strobe.
- to_mem_address  out  ADDR_WIDTH  memory address.
- to_mem_data  out  DATA_WIDTH  memory write data.
- from_mem_data  in  DATA_WIDTH  memory read data; valid the cycle after a read strobe.

Behaviour:
- Memory timing: the memory samples en/rd_en/wr_en/addr/din at the rising edge. Read data appears on from_mem_data the following cycle.
- FSM states are IDLE and MERGE.
- IDLE, winner selection:
  - Winner is DS if ds_req and not (if_req and streak == MAX_STREAK); otherwise IF if if_req; otherwise none.
  - The winner's gnt is combinational in the same cycle; the loser's gnt = 0.
- IDLE, memory op for the winner, driven combinationally the same cycle:
  - Read: en = 1, rd_en = 1, address = winner addr. Next cycle that port's rvalid = 1 and its rdata = from_mem_data. Latency is 1 cycle from gnt to rvalid.
  - DS full write (be = 11): en = 1, wr_en = 1, address/data = ds_addr/ds_wdata. No rvalid.
  - DS partial write (be = 01 or 10):
    - Memory side: issue a read at ds_addr.
    - Latch ds_addr, ds_wdata and ds_be.
    - Go to MERGE.
  - DS write with be = 00: gnt = 1, no memory access, no state change.
- MERGE, exactly 1 cycle:
  - Both gnt = 0 and no rvalid.
  - Drive en = 1, wr_en = 1, address = latched addr.
  - Data = from_mem_data with the enabled lanes replaced by latched wdata.
  - Return to IDLE.
- At most one outstanding read. A 1-bit registered tag (IF/DS) plus a pending flag selects which rvalid fires. Both rvalid are never 1 together.
- rdata values:
  - if_rdata and ds_rdata pass through from_mem_data unconditionally.
  - They are only meaningful when the matching rvalid = 1.
- Idle outputs: when no grant and not in MERGE, all to_mem_* = 0, including address and data.
- Streak counter, width $clog2(MAX_STREAK+1):
  - Increments, saturating at MAX_STREAK, on a DS grant while if_req = 1.
  - Cleared on an IF grant or in any cycle with if_req = 0.
  - Holds during MERGE.
- Requester obligations:
  - req, addr, we, be and wdata stay stable until gnt.
  - Requesters may change them in the cycle after gnt.
  - Requesters may issue back-to-back requests; a new read may be granted in the same cycle the previous read's rvalid is high.
- Reset, synchronous and active-high:
  - State → IDLE; streak, pending and tag → 0.
  - While reset = 1, all gnt, rvalid and to_mem_* outputs are forced to 0.
  - Reset during MERGE aborts the merge write: no wr_en is issued and memory is left unmodified.
  - A read granted in the cycle before reset produces no rvalid.

Decomposition:
- Package mem_port_arbiter_pkg:
  - state enum {IDLE, MERGE};
  - port tag enum {PORT_IF, PORT_DS};
  - localparams for lane masks (LANE_LO = 16'h00FF, LANE_HI = 16'hFF00);
  - function merge_bytes(old, new, be).
- Sub-module mem_port_arbiter_prio: streak counter plus winner select. Inputs are if_req, ds_req and an advance enable; outputs are the winner tag and a valid flag.

Test Plan:
- IF read: mem[0x010] = 16'hBEEF, if_req addr 0x010 → if_gnt same cycle, rd_en = 1; next cycle if_rvalid = 1, if_rdata = 16'hBEEF.
- Byte-write RMW: mem[0x020] = 16'h1234, DS write be = 10, wdata = 16'hAB00 → cycle 0 rd_en = 1; cycle 1 wr_en = 1, to_mem_data = 16'hAB34; an if_req held across both cycles gets no if_gnt until cycle 2.
- Starvation: ds_req and if_req held high for 10 cycles → grant sequence DS,DS,DS,DS,IF,DS,DS,DS,DS,IF.
- Simultaneous reads (DS 0x001, IF 0x002) → ds_gnt first with ds_rvalid next cycle; if_gnt in that same next cycle; if_rvalid the cycle after.
- Reset in MERGE: partial write to 0x030 (old 16'h5555), reset = 1 during the MERGE cycle → no wr_en, mem[0x030] still 16'h5555, all outputs 0, state IDLE.
- Full write plus be = 00: DS write be = 11 of 16'hCAFE to 0x040 → one wr_en cycle, readback 16'hCAFE; DS write be = 00 → ds_gnt = 1, to_mem_mem_enable = 0.
